stop_timer: RTL and testbench



---
 rtl/stop_timer_pkg.sv | 21 ++
 rtl/stop_timer_fsm.sv | 119 +++++++++++
 rtl/stop_timer.sv | 139 +++++++++++++
 tb/tb_stop_timer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stop_timer_pkg.sv
// ---------------------------------------------------------------------------
// stop_timer_pkg
// Shared definitions for the stop_timer stopwatch block.
//   timer_state_e : FSM state type, also the encoding seen on state_o
//   STATE_*       : raw 2-bit encodings of the states
// ---------------------------------------------------------------------------
package stop_timer_pkg;

   localparam logic [1:0] STATE_IDLE  = 2'b00;
   localparam logic [1:0] STATE_RUN   = 2'b01;
   localparam logic [1:0] STATE_PAUSE = 2'b10;
   localparam logic [1:0] STATE_DONE  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = STATE_IDLE,
      RUN   = STATE_RUN,
      PAUSE = STATE_PAUSE,
      DONE  = STATE_DONE
   } timer_state_e;

endpackage : stop_timer_pkg

// File: rtl/stop_timer_fsm.sv
// ---------------------------------------------------------------------------
// stop_timer_fsm
// Control state machine for the stopwatch. Decides the next state from the
// buttons and the current count, and tells the counter datapath what to do.
//
// Ports:
//   clk_4_i    : game tick clock
//   rst_ni     : asynchronous active-low reset
//   start_i    : start / resume request
//   stop_i     : pause request
//   clear_i    : synchronous clear back to IDLE (highest priority)
//   target_i   : terminal count, 0 disables target detection
//   count_i    : current registered count from the datapath
//   state_o    : current state (registered)
//   running_o  : registered, high while in RUN
//   done_o     : registered, high while in DONE
//   inc_en_o   : datapath loads the incremented / wrapped count this edge
//   clr_en_o   : datapath clears count (and lap) this edge
//   wrap_en_o  : this edge wraps MAX_COUNT -> 0
//
// Control strobes are sampled by the datapath flops only, so outputs of the
// block as a whole have no combinational path from inputs.
// ---------------------------------------------------------------------------
module stop_timer_fsm
   import stop_timer_pkg::*;
#(
   parameter int WIDTH     = 5,
   parameter int MAX_COUNT = 2**WIDTH-1,
   parameter int SATURATE  = 0
) (
   input  logic             clk_4_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] target_i,
   input  logic [WIDTH-1:0] count_i,
   output timer_state_e     state_o,
   output logic             running_o,
   output logic             done_o,
   output logic             inc_en_o,
   output logic             clr_en_o,
   output logic             wrap_en_o
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
   localparam logic             SAT   = (SATURATE != 0);

   timer_state_e     state_q, state_d;
   logic             running_q, running_d;
   logic             done_q, done_d;
   logic             at_max;
   logic [WIDTH-1:0] cnt_next;
   logic             target_hit;

   always_comb begin
      state_d    = state_q;
      inc_en_o   = 1'b0;
      clr_en_o   = 1'b0;
      wrap_en_o  = 1'b0;
      at_max     = (count_i == MAX_C);
      cnt_next   = at_max ? '0 : count_i + 1'b1;
      // A target at or below the current count (or above full scale) simply
      // never matches cnt_next until the counter wraps round to it.
      target_hit = (target_i != '0) && (cnt_next == target_i);

      if (clear_i) begin
         state_d  = IDLE;
         clr_en_o = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) state_d = RUN;
            end
            RUN: begin
               if (stop_i) begin
                  state_d = PAUSE;
               end else if (SAT && at_max) begin
                  // Saturating build: hold at full scale and finish.
                  state_d = DONE;
               end else begin
                  inc_en_o = 1'b1;
                  // Target can never be 0, so a wrap edge never hits it;
                  // checking the target first keeps that precedence explicit.
                  if (target_hit)  state_d   = DONE;
                  else if (at_max) wrap_en_o = 1'b1;
               end
            end
            PAUSE: begin
               if (start_i && !stop_i) state_d = RUN;
            end
            DONE: begin
               state_d = DONE;
            end
            default: state_d = IDLE;
         endcase
      end

      running_d = (state_d == RUN);
      done_d    = (state_d == DONE);
   end

   always_ff @(posedge clk_4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign state_o   = state_q;
   assign running_o = running_q;
   assign done_o    = done_q;

endmodule : stop_timer_fsm

// File: rtl/stop_timer.sv
// ---------------------------------------------------------------------------
// stop_timer
// Stopwatch counter for the "Stop It" game datapath, clocked by the slow
// game tick. Start/stop/clear control, programmable target with done flag,
// wrap or saturate at full scale, and an optional lap-capture register.
//
// Optional feature macro: STOP_TIMER_LAP_EN (adds lap_i, lap_o, lap_valid_o).
//
// Ports:
//   clk_4_i     : game tick clock, all updates on rising edge
//   rst_ni      : asynchronous active-low reset
//   start_i     : start / resume request
//   stop_i      : pause request
//   clear_i     : synchronous clear to IDLE
//   target_i    : terminal value, 0 disables target detection
//   lap_i       : (lap build) capture the current count while running
//   lap_o       : (lap build) captured count
//   lap_valid_o : (lap build) lap_o holds a capture
//   count_o     : current count
//   state_o     : current state, timer_state_e encoding
//   running_o   : high in RUN
//   done_o      : high in DONE
//   wrap_o      : one-cycle pulse in the cycle count_o reads 0 after a wrap
//
// There is no valid/ready handshake here: every input is a level sampled on
// each rising clock edge and every output is a registered level.
// ---------------------------------------------------------------------------
module stop_timer
   import stop_timer_pkg::*;
#(
   parameter int WIDTH     = 5,
   parameter int MAX_COUNT = 2**WIDTH-1,
   parameter int SATURATE  = 0
) (
   input  logic             clk_4_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             clear_i,
   input  logic [WIDTH-1:0] target_i,
`ifdef STOP_TIMER_LAP_EN
   input  logic             lap_i,
   output logic [WIDTH-1:0] lap_o,
   output logic             lap_valid_o,
`endif
   output logic [WIDTH-1:0] count_o,
   output logic [1:0]       state_o,
   output logic             running_o,
   output logic             done_o,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

   timer_state_e     state;
   logic             inc_en;
   logic             clr_en;
   logic             wrap_en;
   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;

   stop_timer_fsm #(
      .WIDTH     (WIDTH),
      .MAX_COUNT (MAX_COUNT),
      .SATURATE  (SATURATE)
   ) u_fsm (
      .clk_4_i   (clk_4_i),
      .rst_ni    (rst_ni),
      .start_i   (start_i),
      .stop_i    (stop_i),
      .clear_i   (clear_i),
      .target_i  (target_i),
      .count_i   (count_q),
      .state_o   (state),
      .running_o (running_o),
      .done_o    (done_o),
      .inc_en_o  (inc_en),
      .clr_en_o  (clr_en),
      .wrap_en_o (wrap_en)
   );

   always_comb begin
      count_d = count_q;
      if (clr_en) begin
         count_d = '0;
      end else if (inc_en) begin
         count_d = (count_q == MAX_C) ? '0 : count_q + 1'b1;
      end
      // wrap_en is only ever raised together with the 0 load, so the pulse
      // lines up exactly with the cycle in which count_o reads 0.
      wrap_d = wrap_en;
   end

   always_ff @(posedge clk_4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef STOP_TIMER_LAP_EN
   logic [WIDTH-1:0] lap_q, lap_d;
   logic             lap_valid_q, lap_valid_d;

   always_comb begin
      lap_d       = lap_q;
      lap_valid_d = lap_valid_q;
      if (clr_en) begin
         lap_d       = '0;
         lap_valid_d = 1'b0;
      end else if (lap_i && (state == RUN)) begin
         // Capture the value on display now, before this edge's increment.
         lap_d       = count_q;
         lap_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lap_q       <= '0;
         lap_valid_q <= 1'b0;
      end else begin
         lap_q       <= lap_d;
         lap_valid_q <= lap_valid_d;
      end
   end

   assign lap_o       = lap_q;
   assign lap_valid_o = lap_valid_q;
`endif

   assign count_o = count_q;
   assign state_o = state;
   assign wrap_o  = wrap_q;

endmodule : stop_timer

// File: tb/tb_stop_timer.sv
// ---------------------------------------------------------------------------
// tb_stop_timer
// Directed bench for stop_timer. Two instances share the stimulus: dut_w is
// the default wrapping build, dut_s the saturating build. Expected values are
// hand-derived constants plus a small expected-count queue.
// ---------------------------------------------------------------------------
module tb_stop_timer;

   localparam int W = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         start, stop, clear;
   logic [W-1:0] target;

   logic [W-1:0] cnt_w, cnt_s;
   logic [1:0]   st_w, st_s;
   logic         run_w, run_s, done_w, done_s, wrap_w, wrap_s;
`ifdef STOP_TIMER_LAP_EN
   logic         lap;
   logic [W-1:0] lap_w, lap_s;
   logic         lapv_w, lapv_s;
`endif

   stop_timer #(.WIDTH(W), .SATURATE(0)) dut_w (
      .clk_4_i     (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .stop_i      (stop),
      .clear_i     (clear),
      .target_i    (target),
`ifdef STOP_TIMER_LAP_EN
      .lap_i       (lap),
      .lap_o       (lap_w),
      .lap_valid_o (lapv_w),
`endif
      .count_o     (cnt_w),
      .state_o     (st_w),
      .running_o   (run_w),
      .done_o      (done_w),
      .wrap_o      (wrap_w)
   );

   stop_timer #(.WIDTH(W), .SATURATE(1)) dut_s (
      .clk_4_i     (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .stop_i      (stop),
      .clear_i     (clear),
      .target_i    (target),
`ifdef STOP_TIMER_LAP_EN
      .lap_i       (lap),
      .lap_o       (lap_s),
      .lap_valid_o (lapv_s),
`endif
      .count_o     (cnt_s),
      .state_o     (st_s),
      .running_o   (run_s),
      .done_o      (done_s),
      .wrap_o      (wrap_s)
   );

   // ---------------- scoreboard ----------------
   int           total = 0;
   int           bad   = 0;
   logic [W-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one rising edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic s, input logic p, input logic c);
      start = s;
      stop  = p;
      clear = c;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n  = 1'b0;
      target = '0;
      set_in(1'b0, 1'b0, 1'b0);
`ifdef STOP_TIMER_LAP_EN
      lap = 1'b0;
`endif
      #3;
      chk("rst_count", cnt_w, 0);
      chk("rst_state", st_w, 0);
      chk("rst_run",   run_w, 0);
      chk("rst_done",  done_w, 0);
      chk("rst_wrap",  wrap_w, 0);
      #9 rst_n = 1'b1;

      // 1: reset mid-run, taking effect without an edge
      set_in(1'b1, 1'b0, 1'b0);
      tick();
      chk("t1_start_state", st_w, 1);
      chk("t1_start_count", cnt_w, 0);
      set_in(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) tick();
      chk("t1_count7", cnt_w, 7);
      chk("t1_running", run_w, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t1_async_count", cnt_w, 0);
      chk("t1_async_state", st_w, 0);
      chk("t1_async_run", run_w, 0);
      #2 rst_n = 1'b1;

      // 2: target 10
      target = 5'd10;
      set_in(1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) exp_q.push_back(W'(i));
      while (exp_q.size() > 0) begin
         tick();
         chk("t2_count", cnt_w, exp_q.pop_front());
      end
      chk("t2_state_done", st_w, 3);
      chk("t2_done_o", done_w, 1);
      chk("t2_run_low", run_w, 0);
      set_in(1'b1, 1'b0, 1'b0); tick();
      set_in(1'b0, 1'b1, 1'b0); tick();
      set_in(1'b1, 1'b1, 1'b0); tick();
      set_in(1'b0, 1'b0, 1'b0); tick();
      chk("t2_hold_count", cnt_w, 10);
      chk("t2_hold_state", st_w, 3);
      set_in(1'b0, 1'b0, 1'b1); tick();
      chk("t2_clr_count", cnt_w, 0);
      chk("t2_clr_state", st_w, 0);
      chk("t2_clr_done", done_w, 0);

      // 3: wrap build, no target
      target = '0;
      set_in(1'b1, 1'b0, 1'b0); tick();
      set_in(1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 31; i++) exp_q.push_back(W'(i));
      while (exp_q.size() > 0) begin
         tick();
         chk("t3_count", cnt_w, exp_q.pop_front());
         chk("t3_wrap_low", wrap_w, 0);
      end
      tick();
      chk("t3_wrap_count", cnt_w, 0);
      chk("t3_wrap_pulse", wrap_w, 1);
      chk("t3_wrap_run", run_w, 1);
      chk("t3_wrap_state", st_w, 1);
      tick();
      chk("t3_after_count1", cnt_w, 1);
      chk("t3_after_wrap", wrap_w, 0);
      tick();
      chk("t3_after_count2", cnt_w, 2);

      // 4: saturate build
      set_in(1'b0, 1'b0, 1'b1); tick();
      set_in(1'b1, 1'b0, 1'b0); tick();
      set_in(1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 31; i++) begin
         tick();
         chk("t4_count", cnt_s, i);
         chk("t4_wrap_low", wrap_s, 0);
      end
      chk("t4_state_run", st_s, 1);
      tick();
      chk("t4_sat_count", cnt_s, 31);
      chk("t4_sat_state", st_s, 3);
      chk("t4_sat_done", done_s, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t4_hold_count", cnt_s, 31);
         chk("t4_hold_wrap", wrap_s, 0);
      end

      // 5: pause / resume / lap
      set_in(1'b0, 1'b0, 1'b1); tick();
      chk("t5_clr_sat_state", st_s, 0);
      set_in(1'b0, 1'b1, 1'b0); tick();
      chk("t5_idle_stop_ignored", st_w, 0);
      set_in(1'b1, 1'b0, 1'b0); tick();
      set_in(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      chk("t5_count5", cnt_w, 5);
      set_in(1'b0, 1'b1, 1'b0); tick();
      chk("t5_pause_state", st_w, 2);
      chk("t5_pause_count", cnt_w, 5);
      chk("t5_pause_run", run_w, 0);
      set_in(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_pause_hold", cnt_w, 5);
      end
      set_in(1'b1, 1'b1, 1'b0); tick();
      chk("t5_both_state", st_w, 2);
      chk("t5_both_count", cnt_w, 5);
      set_in(1'b1, 1'b0, 1'b0); tick();
      chk("t5_resume_state", st_w, 1);
      chk("t5_resume_count", cnt_w, 5);
      set_in(1'b0, 1'b0, 1'b0); tick();
      chk("t5_resume_inc", cnt_w, 6);
`ifdef STOP_TIMER_LAP_EN
      chk("t5_lap_idle", lapv_w, 0);
      lap = 1'b1; tick(); lap = 1'b0;
      chk("t5_lap_value", lap_w, 6);
      chk("t5_lap_valid", lapv_w, 1);
`else
      tick();
`endif
      chk("t5_count7", cnt_w, 7);

      // target already passed: never hit while counting up
      target = 5'd3;
      for (int i = 8; i <= 12; i++) begin
         tick();
         chk("t5_passed_target", st_w, 1);
      end
      chk("t5_count12", cnt_w, 12);
      target = '0;

      // 6: clear beats start and stop together
      set_in(1'b1, 1'b1, 1'b1); tick();
      chk("t6_state", st_w, 0);
      chk("t6_count", cnt_w, 0);
      chk("t6_wrap", wrap_w, 0);
`ifdef STOP_TIMER_LAP_EN
      chk("t6_lap_valid", lapv_w, 0);
      chk("t6_lap_value", lap_w, 0);
      set_in(1'b0, 1'b0, 1'b0);
      lap = 1'b1; tick(); lap = 1'b0;
      chk("t6_lap_in_idle", lapv_w, 0);
`endif
      set_in(1'b0, 1'b0, 1'b0); tick();
      chk("t6_idle_hold", cnt_w, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_stop_timer
